store_write_unit: RTL and testbench

- Write-side counterpart of the load data extension path in the MEM stage.
- Accepts store requests (SB/SH/SW) from the pipeline and checks address alignment. Generates byte strobes and lane-replicated write data.
- Queues accepted stores in a small in-order buffer and drains them to the data SRAM-like bus using the req/addr_ok/data_ok handshake.
- Exposes buf_empty so that loads can be ordered behind pending stores.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/store_lane_align.sv | 49 ++++
 rtl/store_write_unit.sv | 113 +++++++++++
 tb/tb_store_write_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared MEM-stage store encodings, FSM states and buffer entry type
package mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;

    // Store op encodings from the pipeline
    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SW  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    // Bus transfer size codes
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } swu_state_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [1:0]            size;
        logic [MEM_STRB_W-1:0] wstrb;
        logic [MEM_DATA_W-1:0] wdata;
    } st_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - combinational store alignment check and byte-lane formatting
//   op         : store op (SB/SH/SW/reserved)
//   addr_lo    : low two bits of the byte address
//   data       : low-justified register value
//   wstrb      : byte strobes for the addressed lanes
//   wdata      : data replicated across all lanes
//   size       : bus size code
//   misaligned : address not aligned to the access size
module store_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]            op,
    input  logic [1:0]            addr_lo,
    input  logic [MEM_DATA_W-1:0] data,
    output logic [MEM_STRB_W-1:0] wstrb,
    output logic [MEM_DATA_W-1:0] wdata,
    output logic [1:0]            size,
    output logic                  misaligned
);

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = data;
        size       = SIZE_W;
        misaligned = 1'b0;
        case (op)
            ST_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
                size  = SIZE_B;
            end
            ST_SH: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{data[15:0]}};
                size       = SIZE_H;
                misaligned = addr_lo[0];
            end
            ST_SW: begin
                wstrb      = 4'b1111;
                size       = SIZE_W;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                // reserved op: consumed upstream without enqueue, never flagged
            end
        endcase
    end

endmodule

// File: rtl/store_write_unit.sv
// rtl/store_write_unit.sv - in-order store buffer draining to a req/addr_ok/data_ok data bus
//   clk, resetn       : clock, asynchronous active-low reset
//   st_*              : store request from the MEM stage (valid/ready, op, addr, data, ades)
//   buf_empty         : no stores buffered or in flight
//   data_*            : data bus request channel driven from the buffer head
module store_write_unit
    import mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [1:0]          st_op,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]   st_data,
    output logic                st_ades,
    output logic                buf_empty,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    swu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    st_entry_t        buf_q [DEPTH];
    st_entry_t        new_entry;
    st_entry_t        head;
    logic             misaligned;
    logic             push;
    logic             pop;

    store_lane_align u_align (
        .op         (st_op),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .wstrb      (new_entry.wstrb),
        .wdata      (new_entry.wdata),
        .size       (new_entry.size),
        .misaligned (misaligned)
    );
    assign new_entry.addr = st_addr;

    // Ready comes only from registered occupancy; resetn gating keeps it low during reset
    assign st_ready = resetn & (count_q != CNT_W'(DEPTH));
    assign st_ades  = st_valid & misaligned;
    assign push     = st_valid & st_ready & ~misaligned & (st_op != ST_RSV);
    // data_ok is only meaningful in WAIT; anything else is a stray pulse
    assign pop      = (state_q == WAIT) & data_data_ok;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            // Looking at count_d lets a fresh enqueue raise data_req on the very next cycle
            IDLE:    if (count_d != '0) state_d = REQ;
            REQ:     if (data_addr_ok) state_d = WAIT;
            WAIT:    if (data_data_ok) state_d = (count_d != '0) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count/pointers
    always_ff @(posedge clk) begin
        if (push) buf_q[wr_ptr_q] <= new_entry;
    end

    assign head       = buf_q[rd_ptr_q];
    assign data_req   = (state_q == REQ);
    assign data_wr    = data_req;
    assign data_size  = head.size;
    assign data_addr  = head.addr;
    assign data_wstrb = head.wstrb;
    assign data_wdata = head.wdata;
    assign buf_empty  = (count_q == '0) & (state_q == IDLE);

endmodule

// File: tb/tb_store_write_unit.sv
// tb/tb_store_write_unit.sv - self-checking bench for store_write_unit
module tb_store_write_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ades;
    logic        buf_empty;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    always #5 clk = ~clk;

    store_write_unit #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_op        (st_op),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ades      (st_ades),
        .buf_empty    (buf_empty),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    bit   outst;
    bit   last_push;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit ref_mis(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'd1) return (a % 2) != 0;
        if (op == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic exp_t ref_entry(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.size = op;
        if (op == 2'd0) begin
            e.wstrb = 4'(1 << (a % 4));
            e.wdata = (d & 32'hFF) * 32'h0101_0101;
        end else if (op == 2'd1) begin
            e.wstrb = 4'(3 << (a % 4));
            e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.wstrb = 4'hF;
            e.wdata = d;
        end
        return e;
    endfunction

    // One bus cycle: drive, check against the model, clock, advance the model.
    task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit aok, input bit dok);
        bit mis, exp_ready, exp_req, acc, cmp;
        st_valid = v; st_op = op; st_addr = a; st_data = d;
        data_addr_ok = aok; data_data_ok = dok;
        #1;
        mis       = ref_mis(op, a);
        exp_ready = q.size() < DEPTH;
        exp_req   = (q.size() > 0) && !outst;
        check("st_ades", 32'(st_ades), 32'(v && mis));
        check("st_ready", 32'(st_ready), 32'(exp_ready));
        check("data_req", 32'(data_req), 32'(exp_req));
        check("data_wr", 32'(data_wr), 32'(exp_req));
        check("buf_empty", 32'(buf_empty), 32'(q.size() == 0 && !outst));
        if (exp_req) begin
            check("data_addr", data_addr, q[0].addr);
            check("data_size", 32'(data_size), 32'(q[0].size));
            check("data_wstrb", 32'(data_wstrb), 32'(q[0].wstrb));
            check("data_wdata", data_wdata, q[0].wdata);
        end
        last_push = v && exp_ready && !mis && (op != 2'd3);
        acc = exp_req && aok;
        cmp = outst && dok;
        @(posedge clk);
        if (cmp) begin
            void'(q.pop_front());
            outst = 1'b0;
        end
        if (acc) outst = 1'b1;
        if (last_push) q.push_back(ref_entry(op, a, d));
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit aok, input bit dok);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 32'h0, aok, dok);
    endtask

    initial begin
        resetn = 1'b0; st_valid = 1'b0; st_op = 2'd0; st_addr = '0; st_data = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; outst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_req", 32'(data_req), 32'd0);
        check("rst_buf_empty", 32'(buf_empty), 32'd1);
        check("rst_st_ready", 32'(st_ready), 32'd0);
        resetn = 1'b1;
        #1;
        check("rel_st_ready", 32'(st_ready), 32'd1);
        @(negedge clk);

        // SB at byte 3, bus accepts at once
        step(1'b1, 2'd0, 32'h1000_0003, 32'h1234_5678, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);

        // SH aligned, then SH misaligned
        step(1'b1, 2'd1, 32'h1000_0002, 32'hAABB_CCDD, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 2'd1, 32'h1000_0001, 32'hAABB_CCDD, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);

        // Reserved op is consumed silently
        step(1'b1, 2'd3, 32'h2000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);

        // Three back-to-back SWs into a two-entry buffer
        step(1'b1, 2'd2, 32'h100, 32'hA0, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'h104, 32'hA4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 32'h108, 32'hA8, 1'b0, 1'b0);
        begin
            bit done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                step(1'b1, 2'd2, 32'h108, 32'hA8, 1'b1, 1'b1);
                done = last_push;
            end
            check("third_sw_accepted", 32'(done), 32'd1);
        end
        idle(10, 1'b1, 1'b1);

        // Slow bus: addr_ok after 3 cycles, data_ok 2 cycles later
        step(1'b1, 2'd0, 32'h3000_0001, 32'h0000_00C3, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b1);
        idle(1, 1'b0, 1'b0);

        // Reset during WAIT with two entries held
        step(1'b1, 2'd2, 32'h200, 32'h11, 1'b0, 1'b0);
        step(1'b1, 2'd2, 32'h204, 32'h22, 1'b1, 1'b0);
        check("pre_rst_outst", 32'(q.size()), 32'd2);
        resetn = 1'b0;
        #1;
        check("midrst_data_req", 32'(data_req), 32'd0);
        check("midrst_buf_empty", 32'(buf_empty), 32'd1);
        check("midrst_st_ready", 32'(st_ready), 32'd0);
        q.delete();
        outst = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (op == 2'd2) ? 2'b00 : (op == 2'd1) ? {a[1], 1'b0} : a[1:0];
            step($urandom_range(0, 1), op, a, $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        idle(40, 1'b1, 1'b1);
        check("drain_empty", 32'(buf_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
